spi_ram_burst: RTL and testbench

- Parametrised single-port RAM behind the SPI slave front-end.
- Decodes 2-bit-tagged command words from the SPI shifter to set addresses, write data and fetch read data.
- Adds auto-increment burst addressing, a registered one-cycle read fetch and a valid/ready return handshake toward the SPI transmitter.
- rx_ready back-pressure protects a pending read from being overrun.

---
 rtl/spi_ram_pkg.sv | 15 +
 rtl/spi_ram_burst_sp_mem.sv | 45 ++++
 rtl/spi_ram_burst.sv | 139 +++++++++++++
 tb/tb_spi_ram_burst.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_ram_pkg.sv
// Shared opcodes and FSM encoding for the SPI-attached burst RAM.
package spi_ram_pkg;

  localparam logic [1:0] OP_SET_WR = 2'b00;
  localparam logic [1:0] OP_WRITE  = 2'b01;
  localparam logic [1:0] OP_SET_RD = 2'b10;
  localparam logic [1:0] OP_READ   = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/spi_ram_burst_sp_mem.sv
// Single-port word array: synchronous write, registered read that resets to 0.
// Out-of-range addresses drop writes and read back as 0.
module spi_ram_sp_mem #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int MEM_DEPTH = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  logic [DATA_W-1:0] mem_q [MEM_DEPTH];
  logic [DATA_W-1:0] rdata_q;
  logic              w_in_range;
  logic              r_in_range;

  assign w_in_range = int'(waddr_i) < MEM_DEPTH;
  assign r_in_range = int'(raddr_i) < MEM_DEPTH;

  // Contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (we_i && w_in_range) begin
      mem_q[waddr_i[IDX_W-1:0]] <= wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= r_in_range ? mem_q[raddr_i[IDX_W-1:0]] : '0;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/spi_ram_burst.sv
// Command decoder, burst address counters and read-return FSM for the SPI RAM.
// Optional sticky protocol error output enabled by SPI_RAM_ERR_EN.
module spi_ram_burst
  import spi_ram_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int MEM_DEPTH = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W+1:0] din,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [DATA_W-1:0] dout,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [1:0]        state_o
`ifdef SPI_RAM_ERR_EN
  ,
  output logic              err
`endif
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);

  state_t            state_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic              rx_ready_q;
  logic              tx_valid_q;

  logic [1:0]        opcode;
  logic [DATA_W-1:0] payload;
  logic              accept;
  logic              mem_we;
  logic              mem_re;

  // Handshakes: a word moves on rx when rx_valid && rx_ready at a rising edge,
  // and on tx when tx_valid && tx_ready; a source holds its data until taken.
  assign opcode  = din[DATA_W+1:DATA_W];
  assign payload = din[DATA_W-1:0];
  assign accept  = rx_valid && rx_ready_q;
  assign mem_we  = accept && (opcode == OP_WRITE);
  assign mem_re  = (state_q == FETCH);

  // Wraps at MEM_DEPTH-1 even when the register could count further.
  function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
    return (a == LAST_ADDR) ? '0 : a + ADDR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      rx_ready_q <= 1'b1;
      tx_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            case (opcode)
              OP_SET_WR: wr_addr_q <= payload[ADDR_W-1:0];
              OP_WRITE:  wr_addr_q <= addr_inc(wr_addr_q);
              OP_SET_RD: rd_addr_q <= payload[ADDR_W-1:0];
              default: begin
                state_q    <= FETCH;
                rx_ready_q <= 1'b0;
              end
            endcase
          end
        end
        FETCH: begin
          tx_valid_q <= 1'b1;
          rd_addr_q  <= addr_inc(rd_addr_q);
          state_q    <= HOLD;
        end
        HOLD: begin
          if (tx_ready) begin
            tx_valid_q <= 1'b0;
            rx_ready_q <= 1'b1;
            state_q    <= IDLE;
          end
        end
        default: begin
          state_q    <= IDLE;
          rx_ready_q <= 1'b1;
          tx_valid_q <= 1'b0;
        end
      endcase
    end
  end

  spi_ram_sp_mem #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (mem_we),
    .waddr_i (wr_addr_q),
    .wdata_i (payload),
    .re_i    (mem_re),
    .raddr_i (rd_addr_q),
    .rdata_o (dout)
  );

  assign rx_ready = rx_ready_q;
  assign tx_valid = tx_valid_q;
  assign state_o  = state_q;

`ifdef SPI_RAM_ERR_EN
  logic wr_set_q;
  logic rd_set_q;
  logic err_q;

  // Commands still execute when flagged; err only records the misuse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_set_q <= 1'b0;
      rd_set_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (accept && (opcode == OP_SET_WR)) wr_set_q <= 1'b1;
      if (accept && (opcode == OP_SET_RD)) rd_set_q <= 1'b1;
      if ((accept && (opcode == OP_WRITE) && !wr_set_q) ||
          (accept && (opcode == OP_READ) && !rd_set_q) ||
          (rx_valid && !rx_ready_q)) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_spi_ram_burst.sv
// Randomised scoreboard bench: two instances (depth 256 and depth 200) share stimulus,
// each compared against a word-level model of the command set.
module tb_spi_ram_burst;
  import spi_ram_pkg::*;

  localparam int DW      = 8;
  localparam int AW      = 8;
  localparam int DEPTH_A = 256;
  localparam int DEPTH_B = 200;

  localparam logic [1:0] C_SET_WR = 2'b00;
  localparam logic [1:0] C_WRITE  = 2'b01;
  localparam logic [1:0] C_SET_RD = 2'b10;
  localparam logic [1:0] C_READ   = 2'b11;

  // ---------------- clock / reset / DUTs
  logic          clk      = 1'b0;
  logic          rst_n    = 1'b0;
  logic [DW+1:0] din      = '0;
  logic          rx_valid = 1'b0;
  logic          tx_ready = 1'b0;

  logic          rx_ready_a, tx_valid_a, rx_ready_b, tx_valid_b;
  logic [DW-1:0] dout_a, dout_b;
  logic [1:0]    state_a, state_b;
`ifdef SPI_RAM_ERR_EN
  logic          err_a, err_b;
`endif

  always #5 clk = ~clk;

  spi_ram_burst #(.DATA_W(DW), .ADDR_W(AW), .MEM_DEPTH(DEPTH_A)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rx_valid), .rx_ready(rx_ready_a),
    .dout(dout_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready), .state_o(state_a)
`ifdef SPI_RAM_ERR_EN
    , .err(err_a)
`endif
  );

  spi_ram_burst #(.DATA_W(DW), .ADDR_W(AW), .MEM_DEPTH(DEPTH_B)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rx_valid), .rx_ready(rx_ready_b),
    .dout(dout_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready), .state_o(state_b)
`ifdef SPI_RAM_ERR_EN
    , .err(err_b)
`endif
  );

  // ---------------- scoreboard
  int            n_vec = 0;
  int            n_err = 0;
  logic [DW-1:0] exp_a[$];
  logic [DW-1:0] exp_b[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: word array per instance plus two address counters.
  logic [DW-1:0] m_mem [2][256];
  int            m_wr [2];
  int            m_rd [2];
  int            m_depth [2] = '{DEPTH_A, DEPTH_B};

  function automatic int next_addr(input int a, input int depth);
    if (a == depth - 1) return 0;
    return (a + 1) % 256;
  endfunction

  task automatic model_cmd(input logic [1:0] op, input logic [7:0] pay);
    logic [DW-1:0] rv;
    for (int k = 0; k < 2; k++) begin
      case (op)
        C_SET_WR: m_wr[k] = int'(pay);
        C_WRITE: begin
          if (m_wr[k] < m_depth[k]) m_mem[k][m_wr[k]] = pay;
          m_wr[k] = next_addr(m_wr[k], m_depth[k]);
        end
        C_SET_RD: m_rd[k] = int'(pay);
        default: begin
          rv = (m_rd[k] < m_depth[k]) ? m_mem[k][m_rd[k]] : '0;
          if (k == 0) exp_a.push_back(rv);
          else        exp_b.push_back(rv);
          m_rd[k] = next_addr(m_rd[k], m_depth[k]);
        end
      endcase
    end
  endtask

  // Monitor: pops one expectation per completed tx handshake.
  always @(negedge clk) begin
    if (rst_n && tx_ready) begin
      if (tx_valid_a) begin
        if (exp_a.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL tx_a_unexpected: dout %0h, no read outstanding", dout_a);
        end else check("dout_a", dout_a, exp_a.pop_front());
      end
      if (tx_valid_b) begin
        if (exp_b.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL tx_b_unexpected: dout %0h, no read outstanding", dout_b);
        end else check("dout_b", dout_b, exp_b.pop_front());
      end
    end
  end

  // ---------------- driver tasks
  task automatic do_reset();
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    tx_ready = 1'b0;
    @(posedge clk); #1;
    check("rst_tx_valid_a", tx_valid_a, 0);
    check("rst_tx_valid_b", tx_valid_b, 0);
    check("rst_rx_ready_a", rx_ready_a, 1);
    check("rst_dout_a", dout_a, 0);
    check("rst_dout_b", dout_b, 0);
    check("rst_state_a", state_a, IDLE);
`ifdef SPI_RAM_ERR_EN
    check("rst_err_a", err_a, 0);
`endif
    exp_a.delete();
    exp_b.delete();
    for (int k = 0; k < 2; k++) begin
      m_wr[k] = 0;
      m_rd[k] = 0;
    end
    rst_n = 1'b1;
  endtask

  task automatic cmd(input logic [1:0] op, input logic [7:0] pay);
    int guard = 0;
    while (!rx_ready_a && guard < 40) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 40) begin
      n_vec++; n_err++;
      $display("FAIL cmd_timeout: rx_ready 0 after %0d cycles, expected 1", guard);
    end
    din      = {op, pay};
    rx_valid = 1'b1;
    model_cmd(op, pay);
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  // READ, hold tx_ready low for `hold` cycles (optionally poking WRITEs), then handshake.
  task automatic do_read(input int hold, input bit poke);
    logic [DW-1:0] want;
    cmd(C_READ, 8'($urandom));
    check("fetch_tx_valid", tx_valid_a, 0);
    check("fetch_rx_ready", rx_ready_a, 0);
    @(posedge clk); #1;
    check("latency_tx_valid", tx_valid_a, 1);
    check("hold_state", state_a, HOLD);
    want = (exp_a.size() > 0) ? exp_a[0] : '0;
    for (int i = 0; i < hold; i++) begin
      if (poke) begin
        din      = {C_WRITE, 8'($urandom)};
        rx_valid = 1'b1;
      end
      @(posedge clk); #1;
      rx_valid = 1'b0;
      check("hold_tx_valid", tx_valid_a, 1);
      check("hold_rx_ready", rx_ready_a, 0);
      check("hold_dout", dout_a, want);
    end
    tx_ready = 1'b1;
    if (poke) begin
      din      = {C_SET_WR, 8'($urandom)};
      rx_valid = 1'b1;
    end
    @(posedge clk); #1;
    tx_ready = 1'b0;
    rx_valid = 1'b0;
    check("done_tx_valid", tx_valid_a, 0);
    check("done_rx_ready", rx_ready_a, 1);
    check("done_dout_kept", dout_a, want);
  endtask

  // ---------------- stimulus
  initial begin
    do_reset();

    cmd(C_SET_WR, 8'h00);
    for (int i = 0; i < 256; i++) cmd(C_WRITE, 8'($urandom));

    // Burst write/read at 0x10
    cmd(C_SET_WR, 8'h10);
    cmd(C_WRITE, 8'hA5);
    cmd(C_WRITE, 8'h5A);
    cmd(C_SET_RD, 8'h10);
    do_read(0, 1'b0);
    do_read(0, 1'b0);

    // Wrap across the top of the address space
    cmd(C_SET_WR, 8'hFF);
    cmd(C_WRITE, 8'h11);
    cmd(C_WRITE, 8'h22);
    cmd(C_SET_RD, 8'hFF);
    do_read(0, 1'b0);
    do_read(0, 1'b0);

    // Back-pressure with dropped writes and a simultaneous command on the handshake
    cmd(C_SET_RD, 8'h10);
    do_read(5, 1'b1);
    do_read(2, 1'b0);

    // Reset while holding a read, then confirm memory survived
    cmd(C_SET_RD, 8'h10);
    cmd(C_READ, 8'h00);
    @(posedge clk); #1;
    check("pre_rst_tx_valid", tx_valid_a, 1);
    do_reset();
    do_read(0, 1'b0);
    cmd(C_SET_RD, 8'h10);
    do_read(1, 1'b0);

    // Depth-200 wrap and out-of-range read
    cmd(C_SET_WR, 8'hC7);
    cmd(C_WRITE, 8'h3C);
    cmd(C_WRITE, 8'hC3);
    cmd(C_SET_RD, 8'hD0);
    do_read(0, 1'b0);
    cmd(C_SET_RD, 8'h00);
    do_read(0, 1'b0);
    cmd(C_SET_RD, 8'hC7);
    do_read(0, 1'b0);

    // Read-after-write on the very next accepted cycle
    cmd(C_SET_WR, 8'h40);
    cmd(C_SET_RD, 8'h40);
    cmd(C_WRITE, 8'h77);
    do_read(0, 1'b0);

    for (int n = 0; n < 300; n++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r == 0)      cmd(C_SET_WR, 8'($urandom));
      else if (r == 1) cmd(C_SET_RD, 8'($urandom));
      else if (r < 6)  cmd(C_WRITE, 8'($urandom));
      else             do_read($urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

`ifdef SPI_RAM_ERR_EN
    do_reset();
    cmd(C_READ, 8'h00);
    check("err_read_unset", err_a, 1);
    @(posedge clk); #1;
    tx_ready = 1'b1;
    @(posedge clk); #1;
    tx_ready = 1'b0;
    cmd(C_SET_WR, 8'h01);
    cmd(C_SET_RD, 8'h01);
    cmd(C_WRITE, 8'h01);
    check("err_sticky", err_a, 1);
    do_reset();
    check("err_cleared", err_a, 0);
`endif

    repeat (3) @(posedge clk);
    #1;
    check("queue_a_drained", exp_a.size(), 0);
    check("queue_b_drained", exp_b.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
